bias_fetch_add: RTL

- Consumer side of the per-layer bias ROM. Accepts 4-lane accumulator vectors tagged with an output-channel group.
- Drives the ROM group address and captures the packed 4-lane bias word one cycle later.
- Adds bias per lane with 18-bit signed saturation, applies optional ReLU, and emits the result on a valid/ready stream toward the layer output buffer.

---
 rtl/layer_pkg.sv | 19 +
 rtl/bias_lane_sat.sv | 42 ++++
 rtl/bias_fetch_add.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/layer_pkg.sv
// Shared constants for the layer datapath: lane geometry, saturation limits
// and the legacy-compatible FSM state encoding of the bias fetch/add stage.
package layer_pkg;

    localparam int unsigned DATA_W    = 18;
    localparam int unsigned N_OUT_ADD = 2;
    localparam int unsigned LANES     = 1 << N_OUT_ADD;

    // Signed saturation bounds for one lane
    localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    // FSM state encoding
    localparam int unsigned  STATE_W = 2;
    localparam logic [1:0]   ST_IDLE = 2'd0;
    localparam logic [1:0]   ST_WAIT = 2'd1;
    localparam logic [1:0]   ST_OUT  = 2'd2;

endpackage

// File: rtl/bias_lane_sat.sv
// One lane of bias addition: signed add with one guard bit, saturation to the
// lane width, then optional ReLU clamp. Purely combinational.
//   acc   : signed accumulator lane
//   bias  : signed bias lane from the ROM
//   res_c : saturated (and optionally rectified) result
module bias_lane_sat #(
    parameter int unsigned LANE_W  = layer_pkg::DATA_W,
    parameter bit          RELU_EN = 1'b1
) (
    input  logic [LANE_W-1:0] acc,
    input  logic [LANE_W-1:0] bias,
    output logic [LANE_W-1:0] res_c
);

    localparam logic [LANE_W-1:0] POS_MAX = {1'b0, {(LANE_W-1){1'b1}}};
    localparam logic [LANE_W-1:0] NEG_MIN = {1'b1, {(LANE_W-1){1'b0}}};

    logic [LANE_W:0]   sum;
    logic              ovf;
    logic [LANE_W-1:0] sat;

    // Sign-extend both operands by one bit so the sum cannot wrap
    assign sum = {acc[LANE_W-1], acc} + {bias[LANE_W-1], bias};

    // Overflow when the guard bit disagrees with the lane sign bit
    assign ovf = sum[LANE_W] ^ sum[LANE_W-1];

    always_comb begin
        sat = sum[LANE_W-1:0];
        if (ovf) begin
            sat = sum[LANE_W] ? NEG_MIN : POS_MAX;
        end
    end

    always_comb begin
        res_c = sat;
        if (RELU_EN && sat[LANE_W-1]) begin
            res_c = '0;
        end
    end

endmodule

// File: rtl/bias_fetch_add.sv
// Bias fetch/add stage. Accepts a packed multi-lane accumulator vector tagged
// with an output-channel group, addresses the registered bias ROM with that
// group, adds the returned bias word lane-wise with signed saturation and
// optional ReLU, and presents the result on a valid/ready stream.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : accumulator vector handshake
//   in_group, in_data    : group tag and packed lanes (lane i at [DATA_W*i +: DATA_W])
//   bias_add             : group address to the bias ROM (valid at the accept edge)
//   bias_out             : ROM data, one cycle after the address edge
//   out_valid/out_ready  : result handshake
//   out_data, out_group  : biased lanes and their group
//   out_last             : asserted for the top group
module bias_fetch_add #(
    parameter int unsigned N_out_add  = 2,
    parameter int unsigned Addr_width = 3,
    parameter int unsigned DATA_W     = layer_pkg::DATA_W,
    parameter bit          RELU_EN    = 1'b1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [Addr_width-1:0]                in_group,
    input  logic [(DATA_W << N_out_add)-1:0]     in_data,
    output logic [Addr_width-1:0]                bias_add,
    input  logic [(DATA_W << N_out_add)-1:0]     bias_out,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [(DATA_W << N_out_add)-1:0]     out_data,
    output logic [Addr_width-1:0]                out_group,
    output logic                                 out_last
);

    import layer_pkg::*;

    localparam int unsigned LANE_CNT = 1 << N_out_add;
    localparam int unsigned VEC_W    = LANE_CNT * DATA_W;
    localparam logic [Addr_width-1:0] TOP_GROUP = {Addr_width{1'b1}};

    logic [STATE_W-1:0]    state_q, state_d;
    logic [VEC_W-1:0]      acc_q, acc_d;
    logic [Addr_width-1:0] grp_q, grp_d;
    logic                  out_valid_q, out_valid_d;
    logic [VEC_W-1:0]      out_data_q, out_data_d;
    logic [Addr_width-1:0] out_group_q, out_group_d;
    logic                  out_last_q, out_last_d;

    logic                  accept_c;
    logic [VEC_W-1:0]      sum_c;

    // Ready in IDLE, or in OUT when the pending result drains this cycle;
    // held low while reset is asserted.
    assign in_ready = rst_n & ((state_q == ST_IDLE) |
                               ((state_q == ST_OUT) & out_ready));
    assign accept_c = in_valid & in_ready;

    // ROM samples the address at the accept edge, then holds the latched group
    assign bias_add = accept_c ? in_group : grp_q;

    // Lane-wise add, saturate, rectify
    for (genvar i = 0; i < LANE_CNT; i++) begin : g_lane
        bias_lane_sat #(
            .LANE_W  (DATA_W),
            .RELU_EN (RELU_EN)
        ) u_sat (
            .acc   (acc_q[DATA_W*i +: DATA_W]),
            .bias  (bias_out[DATA_W*i +: DATA_W]),
            .res_c (sum_c[DATA_W*i +: DATA_W])
        );
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            grp_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_group_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            grp_q       <= grp_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_group_q <= out_group_d;
            out_last_q  <= out_last_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        grp_d       = grp_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_group_d = out_group_q;
        out_last_d  = out_last_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    acc_d   = in_data;
                    grp_d   = in_group;
                    state_d = ST_WAIT;
                end
            end

            // bias_out now carries the latched group's bias word
            ST_WAIT: begin
                out_data_d  = sum_c;
                out_group_d = grp_q;
                out_last_d  = (grp_q == TOP_GROUP);
                out_valid_d = 1'b1;
                state_d     = ST_OUT;
            end

            // Result held stable until the consumer takes it; a new vector
            // may be accepted in the same cycle the old one drains.
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (accept_c) begin
                        acc_d   = in_data;
                        grp_d   = in_group;
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_group = out_group_q;
    assign out_last  = out_last_q;

endmodule
